// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
//
// Output stage behind the fusion-unit column. It accumulates acc_len beats of a
// 4-lane packed partial-sum word into four wide accumulators. It repeats this
// for num_groups groups. Each finished 4-lane result is pushed into a small
// result FIFO that is drained through a valid/ready port.
//
// Optional feature macro: SATURATE_EN
//   defined   : a lane sum that overflows clamps to the representable limit
//   undefined : lane sums wrap modulo 2^ACC_WIDTH
//   The overflow flag asserts in both builds.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          synchronous active-high reset
//   start        latch acc_len/num_groups/signed_mode and begin a run (IDLE only)
//   acc_len      beats per group, 0 encodes 256
//   num_groups   groups per run, 0 encodes 256
//   signed_mode  1: lanes sign-extended, 0: lanes zero-extended
//   psum_in      4 x COL_WIDTH packed partial sums, lane0 in the LSBs
//   psum_valid   psum_in valid this cycle
//   psum_ready   block accepts psum_in this cycle
//   out_data     FIFO head, 4 x ACC_WIDTH, lane0 in the LSBs (0 when empty)
//   out_valid    FIFO non-empty
//   out_ready    consumer pops the head when out_valid & out_ready
//   busy         a run is in progress
//   done         one-cycle pulse after the last group of a run is pushed
//   overflow     sticky lane overflow flag, cleared by an accepted start
// -----------------------------------------------------------------------------
module psum_accumulator #(
  parameter int COL_WIDTH  = 13,
  parameter int ACC_WIDTH  = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               acc_len,
  input  logic [7:0]               num_groups,
  input  logic                     signed_mode,
  input  logic [COL_WIDTH*4-1:0]   psum_in,
  input  logic                     psum_valid,
  output logic                     psum_ready,
  output logic [ACC_WIDTH*4-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = ACC_WIDTH * 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------------

  // Widen one input lane to accumulator width, sign- or zero-extending.
  function automatic logic [ACC_WIDTH-1:0] extend_lane(
    input logic [COL_WIDTH-1:0] lane,
    input logic                 sgn
  );
    logic [ACC_WIDTH-1:0] res;
    if (sgn) begin
      res = ACC_WIDTH'($signed(lane));
    end else begin
      res = ACC_WIDTH'(lane);
    end
    return res;
  endfunction

  // Add one extended lane to its accumulator. The result is {overflow, sum}.
  // Overflow is a signed check when sgn=1 and a carry-out when sgn=0.
  function automatic logic [ACC_WIDTH:0] lane_add(
    input logic [ACC_WIDTH-1:0] acc,
    input logic [ACC_WIDTH-1:0] ext,
    input logic                 sgn
  );
    logic [ACC_WIDTH:0]   wide;
    logic [ACC_WIDTH-1:0] res;
    logic                 ovf;
    wide = {1'b0, acc} + {1'b0, ext};
    res  = wide[ACC_WIDTH-1:0];
    if (sgn) begin
      // Operands of equal sign whose sum flips sign.
      ovf = (acc[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
            (res[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    end else begin
      ovf = wide[ACC_WIDTH];
    end
`ifdef SATURATE_EN
    if (ovf) begin
      if (sgn) begin
        // A signed overflow can only happen with equal operand signs, so the
        // accumulator sign tells which rail to clamp to.
        if (acc[ACC_WIDTH-1]) begin
          res = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
          res = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
      end else begin
        res = {ACC_WIDTH{1'b1}};
      end
    end else begin
      res = res;
    end
`endif
    return {ovf, res};
  endfunction

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  state_t               state_r;
  state_t               state_next_s;

  logic [7:0]           len_m1_r;      // acc_len - 1, so 0 naturally encodes 256
  logic [7:0]           grp_m1_r;      // num_groups - 1, same encoding
  logic                 sgn_r;
  logic [7:0]           beat_cnt_r;
  logic [7:0]           grp_cnt_r;
  logic [ACC_WIDTH-1:0] acc_r [0:3];
  logic                 ovf_r;
  logic                 done_r;

  logic [WORD_W-1:0]    fifo_mem_r [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     count_next_s;
  logic                 out_valid_r;

  logic                 start_ok_s;
  logic                 last_beat_s;
  logic                 last_group_s;
  logic                 fifo_full_s;
  logic                 psum_ready_s;
  logic                 accept_s;
  logic                 push_s;
  logic                 pop_s;
  logic [WORD_W-1:0]    sum_word_s;
  logic [3:0]           lane_ovf_s;
  logic [ACC_WIDTH:0]   lane_res_s;

  // ---------------------------------------------------------------------------
  // Handshake and control decode
  // ---------------------------------------------------------------------------
  assign start_ok_s   = (state_r == ST_IDLE) && start;
  assign last_beat_s  = (beat_cnt_r == len_m1_r);
  assign last_group_s = (grp_cnt_r == grp_m1_r);
  // Full is judged on the registered count: a pop on the same edge does not
  // make room for the push.
  assign fifo_full_s  = (count_r == CNT_W'(FIFO_DEPTH));
  assign psum_ready_s = (state_r == ST_ACCUM) && !(last_beat_s && fifo_full_s);
  assign accept_s     = psum_valid && psum_ready_s;
  assign push_s       = accept_s && last_beat_s;
  assign pop_s        = out_valid_r && out_ready;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: a run ends on the edge its last group is pushed.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_ACCUM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (push_s && last_group_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Per-lane extend-and-add; the pushed word already includes the current beat.
  always_comb begin
    sum_word_s = '0;
    lane_ovf_s = 4'b0000;
    lane_res_s = '0;
    for (int i = 0; i < 4; i++) begin
      lane_res_s = lane_add(acc_r[i],
                            extend_lane(psum_in[i*COL_WIDTH +: COL_WIDTH], sgn_r),
                            sgn_r);
      sum_word_s[i*ACC_WIDTH +: ACC_WIDTH] = lane_res_s[ACC_WIDTH-1:0];
      lane_ovf_s[i]                        = lane_res_s[ACC_WIDTH];
    end
  end

  // Run configuration plus beat and group counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_m1_r   <= 8'd0;
      grp_m1_r   <= 8'd0;
      sgn_r      <= 1'b0;
      beat_cnt_r <= 8'd0;
      grp_cnt_r  <= 8'd0;
    end else if (start_ok_s) begin
      len_m1_r   <= acc_len - 8'd1;
      grp_m1_r   <= num_groups - 8'd1;
      sgn_r      <= signed_mode;
      beat_cnt_r <= 8'd0;
      grp_cnt_r  <= 8'd0;
    end else if (push_s) begin
      beat_cnt_r <= 8'd0;
      grp_cnt_r  <= grp_cnt_r + 8'd1;
    end else if (accept_s) begin
      beat_cnt_r <= beat_cnt_r + 8'd1;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Lane accumulators: cleared at run start and after every completed group.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || start_ok_s || push_s) begin
        acc_r[i] <= '0;
      end else if (accept_s) begin
        acc_r[i] <= sum_word_s[i*ACC_WIDTH +: ACC_WIDTH];
      end else begin
        acc_r[i] <= acc_r[i];
      end
    end
  end

  // Sticky overflow flag and the end-of-run pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= push_s && last_group_s;
      if (start_ok_s) begin
        ovf_r <= 1'b0;
      end else if (accept_s && (lane_ovf_s != 4'b0000)) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Result storage; writes only happen when a slot is free.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= sum_word_s;
    end else begin
      fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy and the registered non-empty flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The head is masked while empty so stale or never-written entries stay hidden
  // after a reset.
  assign out_data   = out_valid_r ? fifo_mem_r[rd_ptr_r] : '0;
  assign out_valid  = out_valid_r;
  assign psum_ready = psum_ready_s;
  assign busy       = (state_r != ST_IDLE);
  assign done       = done_r;
  assign overflow   = ovf_r;

endmodule
